result_port_checker: RTL
========================

// Module: result_port_checker
// PURPOSE
//  Synthesizable, parametrised self-check monitor on the core's data-memory write bus.
//  Arms on a BEGIN symbol written to a test-port address.
//  Compares each subsequent test-port write against an expected-value table, one entry per write.
//  Reports error count, cycle duration, timeout and pass/finish.
//  Sits beside the CPU/D-cache in the top-level bench or the FPGA wrapper.
//  The answer table is external and read through exp_idx/exp_data.
// PARAMETERS
//  ADDR_W      30            word-address width of the write bus
//  DATA_W      32            data width (multiple of 8)
//  TEST_PORT   30'h10        word address monitored
//  BEGIN_SYM   32'h00000168  value that starts checking
//  CHECK_NUM   19            number of writes compared after BEGIN
//  ENDIAN_SWAP 1             1: byte-reverse data before compare (little-endian bus)
//  DUR_W       16            duration counter width
//  TIMEOUT     0             cycles in CHECK before forced report; 0 disables
// PORTS
//  clk        in   1                  clock; all logic on posedge
//  rst        in   1                  synchronous, active-low reset
//  addr       in   ADDR_W             write word address
//  data       in   DATA_W             write data
//  wen        in   1                  write enable; may stay high across D-cache stalls
//  clear      in   1                  synchronous return to IDLE (re-arm)
//  exp_idx    out  $clog2(CHECK_NUM+1)  index of the expected entry for the next write
//  exp_data   in   DATA_W             expected value for exp_idx (combinational table)
//  error_num  out  8                  mismatch count; 8'hFF = not started
//  duration   out  DUR_W              cycles spent in CHECK
//  finish     out  1                  high in REPORT
//  pass       out  1                  finish && error_num==0 && !timed_out
//  timed_out  out  1                  REPORT was entered through TIMEOUT
//  err_valid  out  1                  one-cycle pulse on each mismatch
//  err_idx, err_exp, err_got  out  idx/DATA_W/DATA_W  mismatch details, valid with err_valid
// BEHAVIOUR
//  Reset (rst==0 at posedge) gives:
//   - state=IDLE, error_num=8'hFF, duration=0, exp_idx=0
//   - finish, pass, timed_out, err_valid = 0; err_* = 0; armed=1
//  dmod = ENDIAN_SWAP ? byte-reversed data : data.
//  Write event (evt) = wen && armed && addr==TEST_PORT.
//  Arm flag:
//   - armed clears on any cycle with wen=1, regardless of addr
//   - armed sets on any cycle with wen=0
//   - a stalled write held N cycles therefore counts once
//  IDLE:
//   - error_num=FF, duration=0, exp_idx=0
//   - evt && dmod==BEGIN_SYM -> CHECK, error_num<=0
//   - any other write is ignored
//  CHECK:
//   - duration increments every cycle, saturating at all-ones
//   - on evt: compare dmod with exp_data
//     - mismatch: error_num+1 (saturate at 8'hFE); err_valid=1 next cycle with err_idx=exp_idx, err_exp, err_got=dmod
//     - exp_idx+1
//   - evt with exp_idx==CHECK_NUM-1 -> REPORT; finish rises the cycle after the last write
//   - TIMEOUT!=0 && duration==TIMEOUT-1 with no final evt -> REPORT, timed_out<=1
//   - final evt and timeout in the same cycle: treated as normal completion (timed_out=0)
//  REPORT: all counters frozen; finish=1; writes ignored; held until clear or reset.
//  clear=1: -> IDLE next cycle with reset values except armed; clear beats evt in the same cycle.
//  BEGIN_SYM written during CHECK is compared as an ordinary result (no restart).
//  Latency: evt to updated error_num/err_valid = 1 cycle; no combinational path from data to outputs.
// STRUCTURE
//  Package result_check_pkg:
//   - state enum {IDLE, CHECK, REPORT}
//   - byteswap function
//   - FF "not started" constant
//  Sub-module write_event_detect: arm/disarm flag plus address match; outputs evt.
//  Top holds FSM, counters and mismatch capture.
// TESTING
//  1. Reset; BEGIN at 0x10; 19 writes equal to table -> finish=1, pass=1, error_num=0, err_valid never high.
//  2. Same, but entries 3 and 7 wrong -> err_valid twice (err_idx=3, then 7); error_num=2; pass=0.
//  3. One write with wen held 5 cycles -> exp_idx advances by exactly 1; no extra compare.
//  4. BEGIN written to addr 0x14, then a non-BEGIN value to 0x10 -> stays IDLE; error_num=8'hFF; duration=0.
//  5. TIMEOUT=100, only 5 writes -> REPORT at duration=100; timed_out=1; pass=0; finish=1.
//  6. clear (and separately rst=0) mid-CHECK at idx 9 -> IDLE next cycle; error_num=FF; a new BEGIN restarts at idx 0.

Source files
------------

// File: rtl/result_check_pkg.sv
// Shared types and helpers for the test-port result checker.
// Holds the checker FSM encoding, the error-count sentinels and the byte-reversal helper.
package result_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [7:0] ERR_NOT_STARTED = 8'hFF;
    localparam logic [7:0] ERR_SATURATED   = 8'hFE;

    // Widest bus the byte-reversal helper supports; callers cast in and out.
    localparam int SWAP_MAX_W = 256;

    function automatic logic [SWAP_MAX_W-1:0] byteswap(input logic [SWAP_MAX_W-1:0] d,
                                                       input int nbytes);
        logic [SWAP_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < SWAP_MAX_W / 8; i++) begin
            if (i < nbytes) begin
                r[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
            end else begin
                r[8*i +: 8] = 8'h00;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/write_event_detect.sv
// Turns the raw write strobe into one event per write on the test port.
// A write held across stalls disarms after its first cycle, so it is seen only once.
module write_event_detect #(
    parameter int                ADDR_W    = 30,
    parameter logic [ADDR_W-1:0] TEST_PORT = 30'h10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    output logic              evt
);

    logic armed_r;

    // Arm flag: cleared by any write cycle, re-armed by any idle cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= ~wen;
        end
    end

    assign evt = wen && armed_r && (addr == TEST_PORT);

endmodule

// File: rtl/result_port_checker.sv
// Self-check monitor on the data-memory write bus: arms on BEGIN_SYM at the test port,
// compares the following writes against an external answer table and reports the verdict.
module result_port_checker
    import result_check_pkg::*;
#(
    parameter int                ADDR_W      = 30,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] TEST_PORT   = 30'h10,
    parameter logic [DATA_W-1:0] BEGIN_SYM   = 32'h00000168,
    parameter int                CHECK_NUM   = 19,
    parameter bit                ENDIAN_SWAP = 1'b1,
    parameter int                DUR_W       = 16,
    parameter int                TIMEOUT     = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                addr,
    input  logic [DATA_W-1:0]                data,
    input  logic                             wen,
    input  logic                             clear,
    output logic [$clog2(CHECK_NUM+1)-1:0]   exp_idx,
    input  logic [DATA_W-1:0]                exp_data,
    output logic [7:0]                       error_num,
    output logic [DUR_W-1:0]                 duration,
    output logic                             finish,
    output logic                             pass,
    output logic                             timed_out,
    output logic                             err_valid,
    output logic [$clog2(CHECK_NUM+1)-1:0]   err_idx,
    output logic [DATA_W-1:0]                err_exp,
    output logic [DATA_W-1:0]                err_got
);

    localparam int                IDX_W    = $clog2(CHECK_NUM + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CHECK_NUM - 1);
    localparam bit                TMO_EN   = (TIMEOUT > 32'sd0);
    localparam logic [DUR_W-1:0]  TMO_LAST = DUR_W'(TMO_EN ? TIMEOUT - 1 : 0);
    localparam logic [DUR_W-1:0]  DUR_MAX  = {DUR_W{1'b1}};

    logic              evt_s;
    logic [DATA_W-1:0] dmod_s;
    logic              timeout_hit_s;

    state_t            state_r,     state_s;
    logic [7:0]        error_num_r, error_num_s;
    logic [DUR_W-1:0]  duration_r,  duration_s;
    logic [IDX_W-1:0]  exp_idx_r,   exp_idx_s;
    logic              finish_r,    finish_s;
    logic              pass_r,      pass_s;
    logic              timed_out_r, timed_out_s;
    logic              err_valid_r, err_valid_s;
    logic [IDX_W-1:0]  err_idx_r,   err_idx_s;
    logic [DATA_W-1:0] err_exp_r,   err_exp_s;
    logic [DATA_W-1:0] err_got_r,   err_got_s;

    write_event_detect #(
        .ADDR_W    (ADDR_W),
        .TEST_PORT (TEST_PORT)
    ) u_evt (
        .clk  (clk),
        .rst  (rst),
        .wen  (wen),
        .addr (addr),
        .evt  (evt_s)
    );

    assign dmod_s = ENDIAN_SWAP ? DATA_W'(byteswap(SWAP_MAX_W'(data), DATA_W / 8)) : data;
    assign timeout_hit_s = TMO_EN && (duration_r == TMO_LAST);

    // Next-state, counter and mismatch-capture logic; clear overrides everything else.
    always_comb begin
        state_s     = state_r;
        error_num_s = error_num_r;
        duration_s  = duration_r;
        exp_idx_s   = exp_idx_r;
        timed_out_s = timed_out_r;
        err_valid_s = 1'b0;
        err_idx_s   = err_idx_r;
        err_exp_s   = err_exp_r;
        err_got_s   = err_got_r;

        case (state_r)
            IDLE: begin
                error_num_s = ERR_NOT_STARTED;
                duration_s  = '0;
                exp_idx_s   = '0;
                if (evt_s && (dmod_s == BEGIN_SYM)) begin
                    state_s     = CHECK;
                    error_num_s = 8'h00;
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK: begin
                if (duration_r == DUR_MAX) begin
                    duration_s = duration_r;
                end else begin
                    duration_s = duration_r + DUR_W'(1);
                end
                if (evt_s) begin
                    exp_idx_s = exp_idx_r + IDX_W'(1);
                    if (dmod_s != exp_data) begin
                        err_valid_s = 1'b1;
                        err_idx_s   = exp_idx_r;
                        err_exp_s   = exp_data;
                        err_got_s   = dmod_s;
                        if (error_num_r >= ERR_SATURATED) begin
                            error_num_s = ERR_SATURATED;
                        end else begin
                            error_num_s = error_num_r + 8'd1;
                        end
                    end else begin
                        error_num_s = error_num_r;
                    end
                    // The final write wins over a timeout landing on the same cycle.
                    if (exp_idx_r == LAST_IDX) begin
                        state_s = REPORT;
                    end else if (timeout_hit_s) begin
                        state_s     = REPORT;
                        timed_out_s = 1'b1;
                    end else begin
                        state_s = CHECK;
                    end
                end else if (timeout_hit_s) begin
                    state_s     = REPORT;
                    timed_out_s = 1'b1;
                end else begin
                    state_s = CHECK;
                end
            end
            REPORT: begin
                state_s = REPORT;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (clear) begin
            state_s     = IDLE;
            error_num_s = ERR_NOT_STARTED;
            duration_s  = '0;
            exp_idx_s   = '0;
            timed_out_s = 1'b0;
            err_valid_s = 1'b0;
            err_idx_s   = '0;
            err_exp_s   = '0;
            err_got_s   = '0;
        end else begin
            err_valid_s = err_valid_s;
        end

        finish_s = (state_s == REPORT);
        pass_s   = finish_s && (error_num_s == 8'h00) && !timed_out_s;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            error_num_r <= ERR_NOT_STARTED;
            duration_r  <= '0;
            exp_idx_r   <= '0;
            finish_r    <= 1'b0;
            pass_r      <= 1'b0;
            timed_out_r <= 1'b0;
            err_valid_r <= 1'b0;
            err_idx_r   <= '0;
            err_exp_r   <= '0;
            err_got_r   <= '0;
        end else begin
            state_r     <= state_s;
            error_num_r <= error_num_s;
            duration_r  <= duration_s;
            exp_idx_r   <= exp_idx_s;
            finish_r    <= finish_s;
            pass_r      <= pass_s;
            timed_out_r <= timed_out_s;
            err_valid_r <= err_valid_s;
            err_idx_r   <= err_idx_s;
            err_exp_r   <= err_exp_s;
            err_got_r   <= err_got_s;
        end
    end

    assign exp_idx   = exp_idx_r;
    assign error_num = error_num_r;
    assign duration  = duration_r;
    assign finish    = finish_r;
    assign pass      = pass_r;
    assign timed_out = timed_out_r;
    assign err_valid = err_valid_r;
    assign err_idx   = err_idx_r;
    assign err_exp   = err_exp_r;
    assign err_got   = err_got_r;

endmodule
